wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//   Single-write-port register-file writeback arbiter, directly downstream of the mem stage.
//   Merges fixed-latency load results (reg_addr/reg_dd_val of mem) with ALU results.
//   Load results cannot stall, so they go to a FIFO when the port is busy.
//   A hold signal throttles mem issue so the loads already in flight always fit in the FIFO.
// PARAMETERS
//   AW      6   register address width; address 0 = "no write"
//   DW      32  data width
//   DEPTH   8   load-result FIFO entries; must be >= MEM_LAT+2
//   MEM_LAT 4   cycles from mem-stage issue to result at mem_addr/mem_val
// PORTS
//   clk        in   1      clock, rising edge
//   rstn       in   1      reset, asynchronous, active-low
//   mem_addr   in   AW     load result dest reg (mem reg_addr); 0 = no result this cycle
//   mem_val    in   DW     load result data (mem reg_dd_val)
//   alu_valid  in   1      ALU result offered
//   alu_addr   in   AW     ALU dest reg; 0 = consume with no write
//   alu_val    in   DW     ALU result data
//   alu_ready  out  1      ALU result accepted this cycle (combinational)
//   mem_hold   out  1      issue no new mem op this cycle (combinational from count)
//   rf_we      out  1      register-file write enable (registered)
//   rf_addr    out  AW     register-file write address (registered)
//   rf_wdata   out  DW     register-file write data (registered)
//   fifo_count out  4      current FIFO occupancy, 0..DEPTH
//   ovf_err    out  1      sticky: a load result was dropped because the FIFO was full
// BEHAVIOUR
//   Reset (async, rstn=0): FIFO empty, rd/wr pointers 0, count 0, rf_we 0, rf_addr 0,
//     rf_wdata 0, ovf_err 0. FIFO contents need no reset. Outputs take reset values immediately.
//   push = (mem_addr != 0). Per-cycle selection, highest priority first:
//     1) count>0: pop head and write it. If push, enqueue mem result in the same cycle
//        (net count unchanged).
//     2) count==0 && push: bypass. Write the mem result directly; no enqueue.
//     3) count==0 && !push && alu_valid: alu_ready=1. Write the ALU result if alu_addr!=0,
//        otherwise consume it with rf_we=0.
//     4) otherwise: rf_we=0 next cycle.
//   alu_ready = alu_valid-independent: (count==0 && !push). An ALU transfer occurs when
//     alu_valid && alu_ready. The ALU side holds alu_addr/alu_val stable until accepted.
//   Writeback latency: the selected write appears on rf_we/rf_addr/rf_wdata at the next
//     clock edge (1 cycle). rf_addr/rf_wdata hold their last values when rf_we=0.
//   Ordering: load results are written in arrival order. No load result is ever overtaken
//     by an ALU result that arrives later.
//   mem_hold = (count >= DEPTH-MEM_LAT-1). This guarantees all MEM_LAT in-flight results
//     fit, plus one for the registered count.
//   Full: push while count==DEPTH with no pop cannot happen under case 1 (a pop always
//     accompanies it). If it occurs anyway, the result is dropped and ovf_err is set until
//     reset. Count saturates and never exceeds DEPTH.
//   Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately.
//   Reset mid-operation discards FIFO contents and any pending ALU handshake.
// TESTING
//   T1 reset: rstn=0 async mid-cycle -> rf_we=0, fifo_count=0, ovf_err=0, alu_ready=1
//      immediately.
//   T2 bypass: FIFO empty, mem_addr=5, mem_val=0xDEADBEEF, alu_valid=1 -> alu_ready=0;
//      next cycle rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF; ALU written the cycle after.
//   T3 burst: mem_addr=1..4 on 4 consecutive cycles, alu_valid held (alu_addr=9,
//      alu_val=0x55) -> rf writes 1,2,3,4 in order, then reg 9=0x55. fifo_count never >1.
//   T4 hold: preload count=3 (DEPTH=8) -> mem_hold=1. Count=2 -> mem_hold=0.
//      4 further arrivals after hold -> no ovf_err.
//   T5 addr 0: mem_addr=0 with mem_val=0x1234 -> no write. alu_addr=0 accepted ->
//      alu_ready=1, rf_we=0 next cycle.
//   T6 overflow: force DEPTH+1 pushes with no pops (fault injection) -> ovf_err=1 sticky,
//      fifo_count=8, first 8 values drained in order.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter for a single register-file write port.
// Load results from the mem stage always win the port. If the port is already
// draining the load FIFO, a new load result queues behind the entries it holds.
// ALU results are accepted only when no load result is pending.
module wb_arbiter #(
   parameter int AW      = 6,
   parameter int DW      = 32,
   parameter int DEPTH   = 8,
   parameter int MEM_LAT = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_val,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_addr,
   input  logic [DW-1:0] alu_val,
   output logic          alu_ready,
   output logic          mem_hold,
   output logic          rf_we,
   output logic [AW-1:0] rf_addr,
   output logic [DW-1:0] rf_wdata,
   output logic [3:0]    fifo_count,
   output logic          ovf_err
);

   localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0]  LAST    = PW'(DEPTH - 1);
   localparam logic [3:0]     FULL    = 4'(DEPTH);
   localparam logic [3:0]     HOLD_TH = 4'(DEPTH - MEM_LAT - 1);

   logic [AW-1:0] fifo_addr_q [DEPTH];
   logic [DW-1:0] fifo_data_q [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [3:0]    count_q,  count_d;
   logic          ovf_q,    ovf_d;
   logic          we_q,     we_d;
   logic [AW-1:0] addr_q,   addr_d;
   logic [DW-1:0] data_q,   data_d;

   logic push, empty, full, do_pop, do_enq, drop, do_wr, alu_take;

   // Writeback selection and FIFO bookkeeping for the next cycle
   always_comb begin
      push     = (mem_addr != '0);
      empty    = (count_q == '0);
      full     = (count_q == FULL);
      do_pop   = !empty;
      do_enq   = push && !empty;
      drop     = do_enq && full && !do_pop;
      do_wr    = do_enq && !drop;
      alu_take = empty && !push && alu_valid;

      we_d     = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q || drop;

      if (do_pop) begin
         we_d     = 1'b1;
         addr_d   = fifo_addr_q[rd_ptr_q];
         data_d   = fifo_data_q[rd_ptr_q];
         rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      end else if (push) begin
         we_d   = 1'b1;
         addr_d = mem_addr;
         data_d = mem_val;
      end else if (alu_take && (alu_addr != '0)) begin
         we_d   = 1'b1;
         addr_d = alu_addr;
         data_d = alu_val;
      end

      if (do_wr) begin
         wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      end

      // Count moves only when exactly one of push-into-FIFO / pop happens
      if (do_wr && !do_pop) begin
         count_d = full ? count_q : count_q + 1'b1;
      end else if (!do_wr && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Control and writeback registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   // FIFO storage; contents are qualified by count so they need no reset
   always_ff @(posedge clk) begin
      if (do_wr) begin
         fifo_addr_q[wr_ptr_q] <= mem_addr;
         fifo_data_q[wr_ptr_q] <= mem_val;
      end
   end

   assign alu_ready  = empty && !push;
   assign mem_hold   = (count_q >= HOLD_TH);
   assign rf_we      = we_q;
   assign rf_addr    = addr_q;
   assign rf_wdata   = data_q;
   assign fifo_count = count_q;
   assign ovf_err    = ovf_q;

endmodule
